// File: rtl/fifo_stress_checker_if.sv
// Port bundle between the stress checker and a FIFO under test.
// One bundle carries the write side, the read side and the status flags of that FIFO.
interface fifo_stress_checker_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 10
);
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_wr_full;
  logic                  fifo_almost_full;
  logic [DEPTH_WIDTH:0]  fifo_wr_level;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_empty;
  logic                  fifo_almost_empty;

  // Handshake: a write is accepted at a rising clk edge when fifo_wr_en & !fifo_wr_full,
  // a read when fifo_rd_en & !fifo_rd_empty; read data is valid RD_LATENCY cycles after an accepted read.
  modport master (
    output fifo_wr_en, fifo_wr_data, fifo_rd_en,
    input  fifo_wr_full, fifo_almost_full, fifo_wr_level,
    input  fifo_rd_data, fifo_rd_empty, fifo_almost_empty
  );

  modport slave (
    input  fifo_wr_en, fifo_wr_data, fifo_rd_en,
    output fifo_wr_full, fifo_almost_full, fifo_wr_level,
    output fifo_rd_data, fifo_rd_empty, fifo_almost_empty
  );
endinterface

// File: rtl/fifo_stress_checker.sv
// Traffic generator and checker for a single-clock FIFO: drives one of four traffic modes and
// checks data order, overflow/underflow safety and the reported water level and flags.
module fifo_stress_checker #(
  parameter int          DATA_WIDTH       = 32,
  parameter int          DEPTH_WIDTH      = 10,
  parameter int          RD_LATENCY       = 1,
  parameter int          ALMOST_FULL_NUM  = 508,
  parameter int          ALMOST_EMPTY_NUM = 4,
  parameter int          SETTLE_CYC       = 8,
  parameter int          ERR_WIDTH        = 3,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   tb_rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [DEPTH_WIDTH:0]   burst_len,
  fifo_stress_checker_if.master  fifo,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_WIDTH-1:0]   err_cnt,
  output logic [3:0]             err_flags,
  output logic [3:0]             state_dbg
);

  localparam int              LW          = DEPTH_WIDTH + 1;
  localparam logic [LW-1:0]   DEPTH       = LW'(1) << DEPTH_WIDTH;
  localparam logic [LW-1:0]   AF_LVL      = LW'(ALMOST_FULL_NUM);
  localparam logic [LW-1:0]   AE_LVL      = LW'(ALMOST_EMPTY_NUM);
  localparam int              WDW         = DEPTH_WIDTH + 3;
  localparam logic [WDW-1:0]  WD_LIMIT    = WDW'(4) << DEPTH_WIDTH;
  localparam int              SW          = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [1:0]      M_STREAM    = 2'd1;
  localparam logic [1:0]      M_RANDOM    = 2'd2;
  localparam logic [1:0]      M_OVER      = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_WRITE, S_STREAM, S_RANDOM, S_SETTLE, S_CHECK, S_READ, S_SETTLE2, S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [1:0]             mode_q;
  logic [LW:0]            wr_left;
  logic                   wr_seen;
  logic [DATA_WIDTH-1:0]  wr_cnt, exp_cnt;
  logic [LW-1:0]          occ;
  logic [15:0]            lfsr;
  logic [SW-1:0]          settle_cnt;
  logic [WDW-1:0]         wd_cnt;
  logic [RD_LATENCY-1:0]  rd_vld_pipe;
  logic [DATA_WIDTH-1:0]  exp_pipe [RD_LATENCY];
  logic [LW-1:0]          blen;

  logic wr_en, rd_en, wr_acc, rd_acc, start_acc, chk_mid, chk_end, wd_fire;
  logic data_err, ovf_err, unf_err, lvl_err, any_err, flags_bad;
  logic [ERR_WIDTH-1:0] err_cnt_nxt;

  assign wr_acc  = wr_en & ~fifo.fifo_wr_full;
  assign rd_acc  = rd_en & ~fifo.fifo_rd_empty;
  assign blen    = (burst_len == '0 || burst_len > DEPTH) ? DEPTH : burst_len;
  assign wd_fire = (state != S_IDLE) && (state != S_DONE) && (wd_cnt == WD_LIMIT);

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    start_acc = 1'b0;
    chk_mid   = 1'b0;
    chk_end   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        start_acc = 1'b1;
        case (mode)
          M_STREAM: state_nxt = S_STREAM;
          M_RANDOM: state_nxt = S_RANDOM;
          default:  state_nxt = S_WRITE;
        endcase
      end
      S_WRITE: begin
        wr_en = (wr_left != '0);
        if (wr_left == '0) state_nxt = S_SETTLE;
      end
      S_STREAM: begin
        wr_en = (wr_left != '0);
        rd_en = wr_seen & ~fifo.fifo_rd_empty;
        if (wr_left == '0) state_nxt = S_SETTLE;
      end
      S_RANDOM: begin
        wr_en = lfsr[0] & (wr_left != '0);
        rd_en = lfsr[1] & ~fifo.fifo_rd_empty;
        if (wr_left == '0) state_nxt = S_SETTLE;
      end
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
      S_CHECK: begin
        chk_mid   = 1'b1;
        state_nxt = S_READ;
      end
      S_READ: begin
        rd_en = ~fifo.fifo_rd_empty & (occ != '0);
        if (occ == '0) state_nxt = S_SETTLE2;
      end
      S_SETTLE2: if (settle_cnt == SETTLE_LAST) begin
        chk_end   = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // A stalled FIFO ends the run early rather than hanging the checker.
    if (wd_fire) begin
      state_nxt = S_DONE;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      chk_mid   = 1'b0;
      chk_end   = 1'b0;
    end
  end

  always_comb begin
    flags_bad = (fifo.fifo_wr_level != occ)
              | (fifo.fifo_almost_full != (occ >= AF_LVL))
              | (fifo.fifo_wr_full != (occ == DEPTH))
              | (fifo.fifo_almost_empty != (occ <= AE_LVL));
    data_err  = rd_vld_pipe[RD_LATENCY-1] & (fifo.fifo_rd_data != exp_pipe[RD_LATENCY-1]);
    ovf_err   = wr_acc & (occ == DEPTH);
    unf_err   = rd_acc & (occ == '0);
    lvl_err   = (chk_mid & flags_bad) | wd_fire
              | (chk_end & (flags_bad | (occ != '0) | ~fifo.fifo_rd_empty | ~fifo.fifo_almost_empty));
    any_err   = data_err | ovf_err | unf_err | lvl_err;
    err_cnt_nxt = err_cnt;
    if (start_acc) err_cnt_nxt = '0;
    else if (any_err && err_cnt != '1) err_cnt_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state       <= S_IDLE;
      mode_q      <= '0;
      wr_left     <= '0;
      wr_seen     <= 1'b0;
      wr_cnt      <= '1;
      exp_cnt     <= '1;
      occ         <= '0;
      lfsr        <= LFSR_SEED;
      settle_cnt  <= '0;
      wd_cnt      <= '0;
      rd_vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) exp_pipe[i] <= '0;
      err_cnt     <= '0;
      err_flags   <= '0;
      pass        <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_cnt <= err_cnt_nxt;
      if (state != S_IDLE) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      settle_cnt <= ((state == S_SETTLE || state == S_SETTLE2) && state_nxt == state) ? settle_cnt + 1'b1 : '0;
      if (state == S_IDLE || state == S_DONE || wr_acc || rd_acc) wd_cnt <= '0;
      else if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + 1'b1;

      rd_vld_pipe[0] <= rd_acc;
      exp_pipe[0]    <= exp_cnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_pipe[i] <= rd_vld_pipe[i-1];
        exp_pipe[i]    <= exp_pipe[i-1];
      end

      // Occupancy saturates so one overflow/underflow does not corrupt every later level check.
      case ({wr_acc, rd_acc})
        2'b10:   if (occ != DEPTH) occ <= occ + 1'b1;
        2'b01:   if (occ != '0) occ <= occ - 1'b1;
        default: ;
      endcase

      if (start_acc) begin
        mode_q    <= mode;
        wr_left   <= (mode == M_OVER) ? {1'b0, blen} + (LW+1)'(4) : {1'b0, blen};
        wr_seen   <= 1'b0;
        wr_cnt    <= '1;
        exp_cnt   <= '1;
        err_flags <= '0;
        pass      <= 1'b0;
      end else begin
        if (wr_left != '0 && ((mode_q == M_OVER) ? wr_en : wr_acc)) wr_left <= wr_left - 1'b1;
        if (wr_acc) begin
          wr_seen <= 1'b1;
          wr_cnt  <= wr_cnt - 1'b1;
        end
        if (rd_acc) exp_cnt <= exp_cnt - 1'b1;
        err_flags <= err_flags | {lvl_err, unf_err, ovf_err, data_err};
        if (state_nxt == S_DONE && state != S_DONE) pass <= (err_cnt_nxt == '0);
      end
    end
  end

  assign busy              = (state != S_IDLE);
  assign done              = (state == S_DONE);
  assign state_dbg         = state;
  assign fifo.fifo_wr_en   = wr_en;
  assign fifo.fifo_wr_data = wr_en ? wr_cnt : '0;
  assign fifo.fifo_rd_en   = rd_en;

endmodule
